// File: rtl/counter_slot_scheduler.sv
// Round-robin scheduler sharing one up counter among NREQ timed-slot requesters.
// Ports: clk, rst (async active-low), req/dur in; gnt, cnt, busy, done out.
module counter_slot_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      cnt,
    output logic                  busy,
    output logic [NREQ-1:0]       done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  lim_q, lim_d;
    logic [PW-1:0]     rr_q, rr_d;

    logic [WIDTH-1:0]  dur_a [NREQ];
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic              found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dur_a[i] = dur[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just after the last winner, so the
    // previous grantee is always checked last.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(rr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = '0;
        lim_d   = lim_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                if (found) begin
                    state_d = RUN;
                    gnt_d   = NREQ'(1) << win;
                    rr_d    = win;
                    lim_d   = dur_a[win];
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!(|(req & gnt_q))) begin
                    // Requester withdrew: end slot silently.
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != lim_q) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    // cnt holds lim through the DONE cycle.
                    state_d = DONE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            lim_q   <= '0;
            rr_q    <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lim_q   <= lim_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt  = gnt_q;
    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_slot_scheduler.sv
// Directed bench for counter_slot_scheduler (NREQ=4, WIDTH=4).
// Vector table for single slots, hand sequences for reset/round-robin/full-width.
module tb_counter_slot_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dur;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      cnt;
    logic                  busy;
    logic [NREQ-1:0]       done;

    int checks;
    int failures;

    counter_slot_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dur  (dur),
        .gnt  (gnt),
        .cnt  (cnt),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] dur;
        logic [3:0]  gnt;
        logic [3:0]  cnt;
        logic        busy;
        logic [3:0]  done;
    } vec_t;

    vec_t vt [25];

    task automatic chk(input string nm, input logic [3:0] eg,
                       input logic [3:0] ec, input logic eb,
                       input logic [3:0] ed);
        checks++;
        if ({gnt, cnt, busy, done} !== {eg, ec, eb, ed}) begin
            failures++;
            $display("FAIL %s: got gnt=%b cnt=%0d busy=%b done=%b, want gnt=%b cnt=%0d busy=%b done=%b",
                     nm, gnt, cnt, busy, done, eg, ec, eb, ed);
        end
    endtask

    task automatic step(input string nm, input logic [3:0] eg,
                        input logic [3:0] ec, input logic eb,
                        input logic [3:0] ed);
        @(posedge clk);
        #1;
        chk(nm, eg, ec, eb, ed);
    endtask

    // Structural invariants, checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (!$onehot0(gnt) || !$onehot0(done) || ((gnt & done) != 0)) begin
                failures++;
                $display("FAIL invariant: gnt=%b done=%b", gnt, done);
            end
        end
    end

    initial begin
        // Single requester 0, dur=3: four RUN cycles then DONE.
        vt[0]  = '{4'b0001, 16'h0003, 4'b0001, 4'd0, 1'b1, 4'b0000};
        vt[1]  = '{4'b0001, 16'h0003, 4'b0001, 4'd1, 1'b1, 4'b0000};
        vt[2]  = '{4'b0001, 16'h0003, 4'b0001, 4'd2, 1'b1, 4'b0000};
        vt[3]  = '{4'b0001, 16'h0003, 4'b0001, 4'd3, 1'b1, 4'b0000};
        vt[4]  = '{4'b0001, 16'h0003, 4'b0000, 4'd3, 1'b0, 4'b0001};
        vt[5]  = '{4'b0000, 16'h0003, 4'b0000, 4'd0, 1'b0, 4'b0000};
        vt[6]  = '{4'b0000, 16'h0003, 4'b0000, 4'd0, 1'b0, 4'b0000};
        // dur=0 on requester 1: one RUN cycle.
        vt[7]  = '{4'b0010, 16'h0000, 4'b0010, 4'd0, 1'b1, 4'b0000};
        vt[8]  = '{4'b0010, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0010};
        vt[9]  = '{4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        // Abort requester 2 (dur=10) at cnt=4.
        vt[10] = '{4'b0100, 16'h0A00, 4'b0100, 4'd0, 1'b1, 4'b0000};
        vt[11] = '{4'b0100, 16'h0A00, 4'b0100, 4'd1, 1'b1, 4'b0000};
        vt[12] = '{4'b0100, 16'h0A00, 4'b0100, 4'd2, 1'b1, 4'b0000};
        vt[13] = '{4'b0100, 16'h0A00, 4'b0100, 4'd3, 1'b1, 4'b0000};
        vt[14] = '{4'b0100, 16'h0A00, 4'b0100, 4'd4, 1'b1, 4'b0000};
        vt[15] = '{4'b0000, 16'h0A00, 4'b0000, 4'd0, 1'b0, 4'b0000};
        vt[16] = '{4'b0000, 16'h0A00, 4'b0000, 4'd0, 1'b0, 4'b0000};
        // Requester 1 dur 5 -> 2 mid-slot: still six RUN cycles.
        vt[17] = '{4'b0010, 16'h0050, 4'b0010, 4'd0, 1'b1, 4'b0000};
        vt[18] = '{4'b0010, 16'h0020, 4'b0010, 4'd1, 1'b1, 4'b0000};
        vt[19] = '{4'b0010, 16'h0020, 4'b0010, 4'd2, 1'b1, 4'b0000};
        vt[20] = '{4'b0010, 16'h0020, 4'b0010, 4'd3, 1'b1, 4'b0000};
        vt[21] = '{4'b0010, 16'h0020, 4'b0010, 4'd4, 1'b1, 4'b0000};
        vt[22] = '{4'b0010, 16'h0020, 4'b0010, 4'd5, 1'b1, 4'b0000};
        vt[23] = '{4'b0010, 16'h0020, 4'b0000, 4'd5, 1'b0, 4'b0010};
        vt[24] = '{4'b0000, 16'h0020, 4'b0000, 4'd0, 1'b0, 4'b0000};

        checks   = 0;
        failures = 0;
        rst = 1'b0;
        req = '0;
        dur = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'b0000, 4'd0, 1'b0, 4'b0000);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            req = vt[i].req;
            dur = vt[i].dur;
            step($sformatf("vec%0d", i), vt[i].gnt, vt[i].cnt,
                 vt[i].busy, vt[i].done);
        end

        // Async reset mid-slot: requester 2 (rr_ptr was 1), dur=7.
        req = 4'b0100;
        dur = 16'h0700;
        for (int k = 0; k < 4; k++) begin
            step($sformatf("pre_rst_cnt%0d", k), 4'b0100, 4'(k), 1'b1, 4'b0000);
        end
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", 4'b0000, 4'd0, 1'b0, 4'b0000);
        step("rst_held", 4'b0000, 4'd0, 1'b0, 4'b0000);

        // Release with all requesting: 0 must win (not 3), then 1,2,3,0.
        rst = 1'b1;
        req = 4'b1111;
        dur = 16'h1111;
        for (int s = 0; s < 5; s++) begin
            logic [3:0] w;
            w = 4'b0001 << (s % 4);
            step($sformatf("rr%0d_c0", s), w, 4'd0, 1'b1, 4'b0000);
            step($sformatf("rr%0d_c1", s), w, 4'd1, 1'b1, 4'b0000);
            step($sformatf("rr%0d_done", s), 4'b0000, 4'd1, 1'b0, w);
        end
        req = 4'b0000;
        step("rr_idle", 4'b0000, 4'd0, 1'b0, 4'b0000);

        // Full-width slot on requester 3: cnt 0..15, no wrap.
        req = 4'b1000;
        dur = 16'hF000;
        for (int k = 0; k < 16; k++) begin
            step($sformatf("full_cnt%0d", k), 4'b1000, 4'(k), 1'b1, 4'b0000);
        end
        step("full_done", 4'b0000, 4'd15, 1'b0, 4'b1000);
        req = 4'b0000;
        step("full_idle", 4'b0000, 4'd0, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
